// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for a small RV32I subset.
// Walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK | BRANCH) and
// decodes the ALU, memory and register-enable controls from state and instr.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        alu_msb,
  output logic [2:0]  alu_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_ILLEGAL   = 3'd6,
    S_SPARE     = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLL  = 3'd3;
  localparam logic [2:0] ALU_SRA  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_JALR = 3'd6;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;

  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  state_t state_q, state_d;
  logic   illegal_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_alu, is_lw, is_sw, is_blt, is_jal, is_jalr, legal;
  logic [2:0] ex_sel, ex_imm;
  logic       ex_src_a;
  logic [1:0] ex_src_b;

  // Register fields are consumed by the datapath, not by the sequencer.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Instruction classification and the ALU controls used from EXECUTE onward.
  always_comb begin
    is_alu   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_blt   = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    ex_sel   = ALU_ADD;
    ex_src_a = 1'b0;
    ex_src_b = SRCB_RS2;
    ex_imm   = IMM_I;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  begin is_alu = 1'b1; ex_sel = ALU_ADD; end
            3'b111:  begin is_alu = 1'b1; ex_sel = ALU_AND; end
            3'b100:  begin is_alu = 1'b1; ex_sel = ALU_XOR; end
            3'b001:  begin is_alu = 1'b1; ex_sel = ALU_SLL; end
            default: ;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  begin is_alu = 1'b1; ex_sel = ALU_SUB; end
            3'b101:  begin is_alu = 1'b1; ex_sel = ALU_SRA; end
            default: ;
          endcase
        end
      end
      OP_I: begin
        ex_src_b = SRCB_IMM;
        case (funct3)
          3'b000:  begin is_alu = 1'b1; ex_sel = ALU_ADD; end
          3'b111:  begin is_alu = 1'b1; ex_sel = ALU_AND; end
          3'b100:  begin is_alu = 1'b1; ex_sel = ALU_XOR; end
          3'b001:  begin is_alu = (funct7 == F7_ZERO); ex_sel = ALU_SLL; end
          3'b101:  begin is_alu = (funct7 == F7_ALT);  ex_sel = ALU_SRA; end
          default: ;
        endcase
      end
      OP_LOAD: begin
        is_lw    = (funct3 == 3'b010);
        ex_src_b = SRCB_IMM;
      end
      OP_STORE: begin
        is_sw    = (funct3 == 3'b010);
        ex_src_b = SRCB_IMM;
        ex_imm   = IMM_S;
      end
      OP_BRANCH: begin
        is_blt = (funct3 == 3'b100);
        ex_sel = ALU_SUB;
      end
      OP_JAL: begin
        is_jal   = 1'b1;
        ex_src_a = 1'b1;
        ex_src_b = SRCB_IMM;
        ex_imm   = IMM_J;
      end
      OP_JALR: begin
        is_jalr  = (funct3 == 3'b000);
        ex_sel   = ALU_JALR;
        ex_src_b = SRCB_IMM;
      end
      default: ;
    endcase
    legal = is_alu | is_lw | is_sw | is_blt | is_jal | is_jalr;
  end

  // State register and sticky illegal flag; reset returns to FETCH from anywhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  // Next-state and control decode; everything is gated off while reset is low.
  always_comb begin
    state_d      = state_q;
    alu_sel      = ALU_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RS2;
    imm_sel      = IMM_I;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    illegal      = illegal_q;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXECUTE : S_ILLEGAL;
      S_EXECUTE: begin
        alu_sel   = ex_sel;
        alu_src_a = ex_src_a;
        alu_src_b = ex_src_b;
        imm_sel   = ex_imm;
        if (is_alu) begin
          state_d = S_WRITEBACK;
        end else if (is_lw || is_sw) begin
          state_d = S_MEMORY;
        end else if (is_blt) begin
          state_d = alu_msb ? S_BRANCH : S_FETCH;
        end else if (is_jal || is_jalr) begin
          pc_we   = 1'b1;
          reg_we  = 1'b1;
          wb_sel  = WB_LINK;
          state_d = S_FETCH;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_MEMORY: begin
        alu_sel      = ex_sel;
        alu_src_a    = ex_src_a;
        alu_src_b    = ex_src_b;
        imm_sel      = ex_imm;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        if (mem_ack) begin
          mdr_we  = is_lw;
          state_d = is_lw ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        alu_sel   = ex_sel;
        alu_src_a = ex_src_a;
        alu_src_b = ex_src_b;
        imm_sel   = ex_imm;
        reg_we    = 1'b1;
        wb_sel    = is_lw ? WB_MEM : WB_ALU;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        imm_sel   = IMM_B;
        pc_we     = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      alu_sel      = 3'd0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      imm_sel      = 3'd0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      illegal      = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: builds an expected per-cycle trace for each
// instruction from the instruction-set rules and compares the DUT against it.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ack, alu_msb;
  logic [2:0]  alu_sel, imm_sel, state;
  logic [1:0]  alu_src_b, wb_sel;
  logic        alu_src_a, mem_req, mem_we, mem_addr_sel;
  logic        ir_we, mdr_we, pc_we, reg_we, illegal;

  int errors = 0;
  int checks = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .alu_msb(alu_msb),
    .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [18:0] act;
  assign act = {alu_sel, alu_src_a, alu_src_b, imm_sel, mem_req, mem_we, mem_addr_sel,
                ir_we, mdr_we, pc_we, reg_we, wb_sel, illegal};

  // Legal encodings as (mask, match, kind, alu code).
  // kind: 0 R-type, 1 I-type, 2 lw, 3 sw, 4 blt, 5 jal, 6 jalr
  localparam int NENC = 16;
  logic [31:0] enc_mask [NENC] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000007F, 32'h0000707F};
  logic [31:0] enc_match [NENC] = '{
    32'h00000033, 32'h40000033, 32'h00007033, 32'h00004033, 32'h00001033, 32'h40005033,
    32'h00000013, 32'h00007013, 32'h00004013, 32'h00001013, 32'h40005013,
    32'h00002003, 32'h00002023, 32'h00004063, 32'h0000006F, 32'h00000067};
  int enc_kind [NENC] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6};
  int enc_code [NENC] = '{0, 5, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0};

  typedef struct {
    logic ack;
    logic msb;
    int   st, sel, sa, sb, imm, mreq, mwe, mas, irwe, mdrwe, pcwe, regwe, wb, ill;
  } rec_t;

  rec_t trace[$];

  function automatic void classify(input logic [31:0] w, output int kind, output int code);
    kind = -1;
    code = 0;
    for (int i = 0; i < NENC; i++)
      if ((w & enc_mask[i]) == enc_match[i]) begin
        kind = enc_kind[i];
        code = enc_code[i];
      end
  endfunction

  function automatic rec_t blank(input int st);
    rec_t r;
    r.ack = 1'b0; r.msb = 1'($urandom_range(0, 1)); r.st = st;
    r.sel = 0; r.sa = 0; r.sb = 0; r.imm = 0; r.mreq = 0; r.mwe = 0; r.mas = 0;
    r.irwe = 0; r.mdrwe = 0; r.pcwe = 0; r.regwe = 0; r.wb = 0; r.ill = 0;
    return r;
  endfunction

  function automatic logic [18:0] pack_exp(input rec_t r);
    return {3'(r.sel), 1'(r.sa), 2'(r.sb), 3'(r.imm), 1'(r.mreq), 1'(r.mwe), 1'(r.mas),
            1'(r.irwe), 1'(r.mdrwe), 1'(r.pcwe), 1'(r.regwe), 2'(r.wb), 1'(r.ill)};
  endfunction

  // Expected cycle-by-cycle trace from the fetch of w until control returns to FETCH.
  task automatic build(input logic [31:0] w, input int fwait, input int mwait, input logic msb);
    int   kind, code;
    rec_t r, e;
    trace.delete();
    classify(w, kind, code);
    for (int i = 0; i <= fwait; i++) begin
      r = blank(0);
      r.mreq = 1; r.sa = 1; r.sb = 2;
      if (i == fwait) begin r.ack = 1; r.irwe = 1; r.pcwe = 1; end
      trace.push_back(r);
    end
    r = blank(1);
    r.ack = 1'($urandom_range(0, 1));
    trace.push_back(r);
    if (kind < 0) begin
      for (int i = 0; i < 12; i++) begin
        r = blank(6);
        r.ill = 1; r.ack = 1'($urandom_range(0, 1));
        trace.push_back(r);
      end
      return;
    end
    e = blank(2);
    e.ack = 1'($urandom_range(0, 1));
    case (kind)
      0: e.sel = code;
      1: begin e.sel = code; e.sb = 1; end
      2: e.sb = 1;
      3: begin e.sb = 1; e.imm = 1; end
      4: begin e.sel = 5; e.msb = msb; end
      5: begin e.sa = 1; e.sb = 1; e.imm = 3; e.pcwe = 1; e.regwe = 1; e.wb = 2; end
      default: begin e.sel = 6; e.sb = 1; e.pcwe = 1; e.regwe = 1; e.wb = 2; end
    endcase
    trace.push_back(e);
    if (kind == 2 || kind == 3) begin
      for (int i = 0; i <= mwait; i++) begin
        r = blank(3);
        r.sel = e.sel; r.sa = e.sa; r.sb = e.sb; r.imm = e.imm;
        r.mreq = 1; r.mas = 1; r.mwe = (kind == 3);
        if (i == mwait) begin r.ack = 1; r.mdrwe = (kind == 2); end
        trace.push_back(r);
      end
    end
    if (kind <= 2) begin
      r = blank(4);
      r.sel = e.sel; r.sa = e.sa; r.sb = e.sb; r.imm = e.imm;
      r.regwe = 1; r.wb = (kind == 2) ? 1 : 0;
      r.ack = 1'($urandom_range(0, 1));
      trace.push_back(r);
    end
    if (kind == 4 && msb) begin
      r = blank(5);
      r.sa = 1; r.sb = 1; r.imm = 2; r.pcwe = 1;
      r.ack = 1'($urandom_range(0, 1));
      trace.push_back(r);
    end
  endtask

  // Plays up to 'limit' records of the trace, comparing state and controls each cycle.
  task automatic run_trace(input string name, input int limit);
    for (int i = 0; i < trace.size() && i < limit; i++) begin
      mem_ack = trace[i].ack;
      alu_msb = trace[i].msb;
      @(negedge clk);
      checks++;
      if (state !== 3'(trace[i].st)) begin
        errors++;
        $display("FAIL %s[%0d] state: got %0d want %0d", name, i, state, trace[i].st);
      end
      checks++;
      if (act !== pack_exp(trace[i])) begin
        errors++;
        $display("FAIL %s[%0d] controls (st %0d): got %h want %h", name, i, trace[i].st,
                 act, pack_exp(trace[i]));
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = $urandom; mem_ack = 1'b1; alu_msb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if (act !== 19'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", act); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: got mem_req=%b state=%0d want 1/0", mem_req, state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    instr = 32'h002081B3;
    build(instr, 2, 0, 1'b0);
    run_trace("add", 100);
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL add_return: got %0d want 0", state); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    instr = 32'h402081B3;
    build(instr, 0, 0, 1'b0);
    run_trace("sub", 100);
  endtask

  task automatic test_blt();
    instr = 32'h0020C463;
    build(instr, 1, 0, 1'b1);
    run_trace("blt_taken", 100);
    build(instr, 0, 0, 1'b0);
    run_trace("blt_not_taken", 100);
  endtask

  task automatic test_lw();
    instr = 32'h0000A183;
    build(instr, 0, 2, 1'b0);
    run_trace("lw", 100);
  endtask

  task automatic test_back_to_back();
    int idx;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, NENC - 1);
      instr = ($urandom & ~enc_mask[idx]) | enc_match[idx];
      build(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      run_trace("random", 100);
    end
  endtask

  task automatic test_illegal();
    instr = 32'h00000000;
    build(instr, 1, 0, 1'b0);
    run_trace("illegal", 100);
    rst_n = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL illegal_in_reset: got illegal=%b mem_req=%b want 0/0", illegal, mem_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_cleared: got state=%0d illegal=%b want 0/0", state, illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_memory();
    instr = 32'h0000A183;
    build(instr, 0, 5, 1'b0);
    run_trace("mid_mem", 5);
    rst_n = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_mem_reset: got state=%0d mem_req=%b want 3/0", state, mem_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_after: got state=%0d mem_req=%b want 0/1", state, mem_req);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'd0; mem_ack = 1'b0; alu_msb = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_blt();
    test_lw();
    test_back_to_back();
    test_reset_mid_memory();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
